// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU/shift encodings, status bit positions and the NZCV flag payload.
package cpu_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned RF_DEPTH = 16;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned AMT_W    = 8;
   localparam int unsigned ROT_W    = 5;

   localparam int unsigned STAT_N = 31;
   localparam int unsigned STAT_Z = 30;
   localparam int unsigned STAT_C = 29;
   localparam int unsigned STAT_V = 28;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_ORR = 3'b011,
      ALU_EOR = 3'b100,
      ALU_MOV = 3'b101,
      ALU_MVN = 3'b110,
      ALU_BIC = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

endpackage

// File: rtl/regfile.sv
// 16x32 register file: one synchronous write port, three combinational read ports.
module regfile
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic              w_en,
   input  logic [DATA_W-1:0] w_data,
   input  logic [ADDR_W-1:0] ra_a,
   input  logic [ADDR_W-1:0] ra_b,
   input  logic [ADDR_W-1:0] ra_s,
   output logic [DATA_W-1:0] rd_a_c,
   output logic [DATA_W-1:0] rd_b_c,
   output logic [DATA_W-1:0] rd_s_c
);

   logic [DATA_W-1:0] regs [RF_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RF_DEPTH); i++) regs[i] <= '0;
      end else if (w_en) begin
         regs[w_addr] <= w_data;
      end
   end

   // No write bypass: a read in the write cycle sees the old contents.
   assign rd_a_c = regs[ra_a];
   assign rd_b_c = regs[ra_b];
   assign rd_s_c = regs[ra_s];

endmodule

// File: rtl/datapath.sv
// Execute-stage datapath: register file, operand latches, barrel shifter on B, ALU,
// result register C and NZCV status register.
module datapath
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] datapath_in,
   input  logic              wb_sel,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] A_addr,
   input  logic [ADDR_W-1:0] B_addr,
   input  logic [ADDR_W-1:0] shift_addr,
   input  logic              en_A,
   input  logic              en_B,
   input  logic              en_S,
   input  logic              sel_shift,
   input  logic [DATA_W-1:0] shift_imme,
   input  logic [1:0]        shift_op,
   input  logic              sel_A,
   input  logic              sel_B,
   input  logic [DATA_W-1:0] imme_data,
   input  logic [2:0]        ALU_op,
   input  logic              en_C,
   input  logic              en_status,
   output logic [DATA_W-1:0] datapath_out,
   output logic [DATA_W-1:0] status_out
);

   logic [DATA_W-1:0] a_q, b_q, s_q, c_q;
   nzcv_t             flags_q, flags_c;
   logic [DATA_W-1:0] rd_a_c, rd_b_c, rd_s_c, wb_data_c;
   logic [DATA_W-1:0] shifted_c, op_a_c, op_b_c, alu_res_c;
   logic [DATA_W:0]   sum_c;
   logic [AMT_W-1:0]  amt_c;
   logic [ROT_W-1:0]  rot_c;
   alu_op_e           alu_op_c;
   shift_op_e         shift_op_c;
   logic              unused_s_hi;

   // Write-back takes the registered C, never the live ALU output.
   assign wb_data_c = wb_sel ? datapath_in : c_q;

   regfile u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .w_addr (w_addr),
      .w_en   (w_en),
      .w_data (wb_data_c),
      .ra_a   (A_addr),
      .ra_b   (B_addr),
      .ra_s   (shift_addr),
      .rd_a_c (rd_a_c),
      .rd_b_c (rd_b_c),
      .rd_s_c (rd_s_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         s_q <= '0;
      end else begin
         if (en_A) a_q <= rd_a_c;
         if (en_B) b_q <= rd_b_c;
         if (en_S) s_q <= sel_shift ? rd_s_c : shift_imme;
      end
   end

   // Only the low byte of S is a shift amount.
   assign amt_c       = s_q[AMT_W-1:0];
   assign rot_c       = amt_c[ROT_W-1:0];
   assign unused_s_hi = ^s_q[DATA_W-1:AMT_W];
   assign shift_op_c  = shift_op_e'(shift_op);
   assign alu_op_c    = alu_op_e'(ALU_op);

   always_comb begin
      shifted_c = b_q;
      if (amt_c != '0) begin
         unique case (shift_op_c)
            SH_LSL: shifted_c = (amt_c >= AMT_W'(DATA_W)) ? '0 : (b_q << rot_c);
            SH_LSR: shifted_c = (amt_c >= AMT_W'(DATA_W)) ? '0 : (b_q >> rot_c);
            SH_ASR: shifted_c = (amt_c >= AMT_W'(DATA_W)) ? {DATA_W{b_q[DATA_W-1]}}
                                                         : DATA_W'($signed(b_q) >>> rot_c);
            SH_ROR: shifted_c = (b_q >> rot_c) | (b_q << ((ROT_W+1)'(DATA_W) - {1'b0, rot_c}));
         endcase
      end
   end

   assign op_a_c = sel_A ? '0 : a_q;
   assign op_b_c = sel_B ? imme_data : shifted_c;

   always_comb begin
      sum_c     = '0;
      alu_res_c = '0;
      flags_c   = '0;
      unique case (alu_op_c)
         ALU_ADD: begin
            sum_c     = {1'b0, op_a_c} + {1'b0, op_b_c};
            alu_res_c = sum_c[DATA_W-1:0];
            flags_c.c = sum_c[DATA_W];
            flags_c.v = (op_a_c[DATA_W-1] == op_b_c[DATA_W-1]) &&
                        (alu_res_c[DATA_W-1] != op_a_c[DATA_W-1]);
         end
         ALU_SUB: begin
            // Carry out of A + ~B + 1 is NOT borrow.
            sum_c     = {1'b0, op_a_c} + {1'b0, ~op_b_c} + (DATA_W+1)'(1);
            alu_res_c = sum_c[DATA_W-1:0];
            flags_c.c = sum_c[DATA_W];
            flags_c.v = (op_a_c[DATA_W-1] != op_b_c[DATA_W-1]) &&
                        (alu_res_c[DATA_W-1] != op_a_c[DATA_W-1]);
         end
         ALU_AND: alu_res_c = op_a_c & op_b_c;
         ALU_ORR: alu_res_c = op_a_c | op_b_c;
         ALU_EOR: alu_res_c = op_a_c ^ op_b_c;
         ALU_MOV: alu_res_c = op_b_c;
         ALU_MVN: alu_res_c = ~op_b_c;
         ALU_BIC: alu_res_c = op_a_c & ~op_b_c;
      endcase
      flags_c.n = alu_res_c[DATA_W-1];
      flags_c.z = (alu_res_c == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q     <= '0;
         flags_q <= '0;
      end else begin
         if (en_C)      c_q     <= alu_res_c;
         if (en_status) flags_q <= flags_c;
      end
   end

   assign datapath_out = c_q;

   always_comb begin
      status_out         = '0;
      status_out[STAT_N] = flags_q.n;
      status_out[STAT_Z] = flags_q.z;
      status_out[STAT_C] = flags_q.c;
      status_out[STAT_V] = flags_q.v;
   end

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized bench for datapath against an arithmetic reference model.
module tb_datapath;

   logic        clk, rst_n;
   logic [31:0] datapath_in, shift_imme, imme_data;
   logic        wb_sel, w_en, en_A, en_B, en_S, sel_shift, sel_A, sel_B, en_C, en_status;
   logic [3:0]  w_addr, A_addr, B_addr, shift_addr;
   logic [1:0]  shift_op;
   logic [2:0]  ALU_op;
   logic [31:0] datapath_out, status_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_rf [16];
   logic [31:0] m_a, m_b, m_s, m_c;
   logic [3:0]  m_st;

   localparam longint S_MAX = 64'sd2147483647;
   localparam longint S_MIN = -64'sd2147483648;

   datapath dut (
      .clk(clk), .rst_n(rst_n), .datapath_in(datapath_in), .wb_sel(wb_sel),
      .w_addr(w_addr), .w_en(w_en), .A_addr(A_addr), .B_addr(B_addr),
      .shift_addr(shift_addr), .en_A(en_A), .en_B(en_B), .en_S(en_S),
      .sel_shift(sel_shift), .shift_imme(shift_imme), .shift_op(shift_op),
      .sel_A(sel_A), .sel_B(sel_B), .imme_data(imme_data), .ALU_op(ALU_op),
      .en_C(en_C), .en_status(en_status), .datapath_out(datapath_out),
      .status_out(status_out)
   );

   always #5 clk = ~clk;

   // Shifts as multiply / floor-divide by powers of two; rotate via a doubled word.
   function automatic logic [31:0] ref_shift(input logic [31:0] b, input logic [7:0] amt,
                                             input logic [1:0] op);
      longint      sv, p, q;
      logic [63:0] dbl;
      if (amt == 8'd0) return b;
      case (op)
         2'd0: return (amt >= 8'd32) ? 32'd0 : 32'(64'(b) * (64'd1 << amt));
         2'd1: return (amt >= 8'd32) ? 32'd0 : 32'(64'(b) / (64'd1 << amt));
         2'd2: begin
            if (amt >= 8'd32) return b[31] ? 32'hFFFF_FFFF : 32'd0;
            sv = longint'($signed(b));
            p  = longint'(64'd1 << amt);
            q  = sv / p;
            if (sv < 0 && q * p != sv) q = q - 1;
            return 32'(q);
         end
         default: begin
            dbl = {b, b};
            return 32'(dbl >> amt[4:0]);
         end
      endcase
   endfunction

   function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, output logic [31:0] r,
                                   output logic [3:0] f);
      longint ua, ub, sa, sb, us, ss;
      logic   c, v;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         3'd0: begin
            us = ua + ub;
            ss = sa + sb;
            r  = 32'(us);
            c  = (us > 64'sd4294967295);
            v  = (ss > S_MAX) || (ss < S_MIN);
         end
         3'd1: begin
            ss = sa - sb;
            r  = 32'(ua - ub);
            c  = (ua >= ub);
            v  = (ss > S_MAX) || (ss < S_MIN);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = b;
         3'd6: r = ~b;
         default: r = a & ~b;
      endcase
      f = {r[31], (r == 32'd0), c, v};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      datapath_in = 32'd0; wb_sel = 1'b0; w_addr = 4'd0; w_en = 1'b0;
      A_addr = 4'd0; B_addr = 4'd0; shift_addr = 4'd0;
      en_A = 1'b0; en_B = 1'b0; en_S = 1'b0; sel_shift = 1'b0; shift_imme = 32'd0;
      shift_op = 2'd0; sel_A = 1'b0; sel_B = 1'b0; imme_data = 32'd0; ALU_op = 3'd0;
      en_C = 1'b0; en_status = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
      m_a = 32'd0; m_b = 32'd0; m_s = 32'd0; m_c = 32'd0; m_st = 4'd0;
   endtask

   // One clock with the current inputs: predict, clock, then compare both outputs.
   task automatic step();
      logic [31:0] sh, oa, ob, r, wbd;
      logic [3:0]  f;
      sh  = ref_shift(m_b, m_s[7:0], shift_op);
      oa  = sel_A ? 32'd0 : m_a;
      ob  = sel_B ? imme_data : sh;
      ref_alu(oa, ob, ALU_op, r, f);
      wbd = wb_sel ? datapath_in : m_c;
      @(posedge clk);
      #1;
      if (en_A) m_a = m_rf[A_addr];
      if (en_B) m_b = m_rf[B_addr];
      if (en_S) m_s = sel_shift ? m_rf[shift_addr] : shift_imme;
      if (en_C) m_c = r;
      if (en_status) m_st = f;
      if (w_en) m_rf[w_addr] = wbd;
      check("model_c", datapath_out, m_c);
      check("model_status", status_out, {m_st, 28'd0});
   endtask

   task automatic write_reg(input logic [3:0] addr, input logic [31:0] val);
      idle(); wb_sel = 1'b1; datapath_in = val; w_addr = addr; w_en = 1'b1; step();
   endtask

   task automatic shift_mov(input logic [1:0] op, input logic [31:0] exp, input string tag);
      idle(); shift_op = op; ALU_op = 3'd5; en_C = 1'b1; en_status = 1'b1; step();
      check(tag, datapath_out, exp);
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      idle();
      model_clear();
      #2;
      check("reset_c", datapath_out, 32'd0);
      check("reset_status", status_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) write_reg(4'(i), 32'(i));
      for (int i = 0; i < 16; i++) begin
         idle(); A_addr = 4'(i); B_addr = 4'(i); en_A = 1'b1; en_B = 1'b1; en_S = 1'b1; step();
         idle(); ALU_op = 3'd5; en_C = 1'b1; en_status = 1'b1; step();
         check("rf_readback", datapath_out, 32'(i));
      end

      idle(); A_addr = 4'd1; B_addr = 4'd2; shift_addr = 4'd1; sel_shift = 1'b1;
      en_A = 1'b1; en_B = 1'b1; en_S = 1'b1; step();
      idle(); shift_op = 2'd0; ALU_op = 3'd0; en_C = 1'b1; en_status = 1'b1; step();
      check("lsl_add_c", datapath_out, 32'd5);
      check("lsl_add_status", status_out, 32'd0);

      idle(); sel_A = 1'b1; sel_B = 1'b1; imme_data = 32'd12; ALU_op = 3'd1;
      en_C = 1'b1; en_status = 1'b1; step();
      check("sub_neg_c", datapath_out, 32'hFFFF_FFF4);
      check("sub_neg_status", status_out, 32'h8000_0000);

      idle(); wb_sel = 1'b0; w_en = 1'b1; w_addr = 4'd0; step();
      idle(); B_addr = 4'd0; en_B = 1'b1; en_S = 1'b1; step();
      idle(); sel_A = 1'b1; ALU_op = 3'd1; en_C = 1'b1; en_status = 1'b1; step();
      check("wb_c_sub_c", datapath_out, 32'd12);
      check("wb_c_sub_status", status_out, 32'd0);

      write_reg(4'd3, 32'h8000_0001);
      idle(); B_addr = 4'd3; en_B = 1'b1; en_S = 1'b1; shift_imme = 32'd1; step();
      shift_mov(2'd2, 32'hC000_0000, "asr1");
      shift_mov(2'd3, 32'hC000_0000, "ror1");
      idle(); en_S = 1'b1; shift_imme = 32'd32; step();
      shift_mov(2'd1, 32'd0, "lsr32");
      shift_mov(2'd0, 32'd0, "lsl32");
      shift_mov(2'd2, 32'hFFFF_FFFF, "asr32");
      shift_mov(2'd3, 32'h8000_0001, "ror32");
      idle(); en_S = 1'b1; shift_imme = 32'd256; step();
      shift_mov(2'd1, 32'h8000_0001, "amt256_is_zero");

      write_reg(4'd4, 32'h7FFF_FFFF);
      idle(); A_addr = 4'd4; en_A = 1'b1; step();
      idle(); sel_B = 1'b1; imme_data = 32'd1; ALU_op = 3'd0; en_C = 1'b1; en_status = 1'b1; step();
      check("add_ovf_c", datapath_out, 32'h8000_0000);
      check("add_ovf_status", status_out, 32'h9000_0000);

      write_reg(4'd6, 32'hFFFF_FFFF);
      idle(); A_addr = 4'd6; en_A = 1'b1; step();
      idle(); sel_B = 1'b1; imme_data = 32'd1; ALU_op = 3'd0; en_C = 1'b1; en_status = 1'b1; step();
      check("add_carry_status", status_out, 32'h6000_0000);

      idle(); wb_sel = 1'b1; datapath_in = 32'h0000_DEAD; w_addr = 4'd5; w_en = 1'b1;
      A_addr = 4'd5; en_A = 1'b1; step();
      idle(); sel_B = 1'b1; ALU_op = 3'd3; en_C = 1'b1; step();
      check("no_bypass", datapath_out, 32'd5);

      repeat (400) begin
         datapath_in = $urandom(); wb_sel = 1'($urandom()); w_addr = 4'($urandom());
         w_en = 1'($urandom()); A_addr = 4'($urandom()); B_addr = 4'($urandom());
         shift_addr = 4'($urandom()); en_A = 1'($urandom()); en_B = 1'($urandom());
         en_S = 1'($urandom()); sel_shift = 1'($urandom()); shift_op = 2'($urandom());
         case ($urandom_range(0, 3))
            0: shift_imme = 32'($urandom_range(0, 40));
            1: shift_imme = 32'($urandom_range(250, 260));
            2: shift_imme = 32'd0;
            default: shift_imme = $urandom();
         endcase
         sel_A = 1'($urandom()); sel_B = 1'($urandom());
         case ($urandom_range(0, 3))
            0: imme_data = 32'h7FFF_FFFF;
            1: imme_data = 32'h8000_0000;
            2: imme_data = 32'($urandom_range(0, 2));
            default: imme_data = $urandom();
         endcase
         ALU_op = 3'($urandom()); en_C = 1'($urandom()); en_status = 1'($urandom());
         step();
      end

      idle(); sel_A = 1'b1; sel_B = 1'b1; imme_data = 32'd12; ALU_op = 3'd1;
      en_C = 1'b1; en_status = 1'b1; step();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check("midreset_c", datapath_out, 32'd0);
      check("midreset_status", status_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(); B_addr = 4'd4; en_B = 1'b1; en_S = 1'b1; step();
      idle(); ALU_op = 3'd5; en_C = 1'b1; en_status = 1'b1; step();
      check("rf_cleared", datapath_out, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
